// File: rtl/step_dir_conditioner_pkg.sv
// step_dir_conditioner_pkg: shared FSM encoding and parameter defaults for the STEP/DIR front end
package step_dir_conditioner_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;
  localparam int SYNC_STAGES_DEF      = 2;
  localparam int FILTER_CYCLES_DEF    = 4;
  localparam int DIR_SETUP_CYCLES_DEF = 8;
  localparam int STEP_GAP_CYCLES_DEF  = 4;
  localparam int PEND_WIDTH_DEF       = 4;
  localparam int POS_WIDTH_DEF        = 32;
endpackage

// File: rtl/sync_glitch_filter.sv
// sync_glitch_filter: pin synchroniser, optional inversion, then a stable-count deglitcher
module sync_glitch_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
)(
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic inv,
  output logic q
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_q;
  logic                   w_raw, w_diff, w_done;
  assign w_raw  = r_sync[SYNC_STAGES-1] ^ inv;
  assign w_diff = w_raw ^ r_q;
  assign w_done = w_diff && (r_cnt == CW'(FILTER_CYCLES - 1));
  assign q      = r_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_q    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_cnt  <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
      r_q    <= w_done ? w_raw : r_q;
    end
  end
endmodule

// File: rtl/step_dir_conditioner.sv
// step_dir_conditioner: deglitched STEP/DIR front end with dir setup hold, step pacing and position count
module step_dir_conditioner
  import step_dir_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES      = SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES    = FILTER_CYCLES_DEF,
  parameter int DIR_SETUP_CYCLES = DIR_SETUP_CYCLES_DEF,
  parameter int STEP_GAP_CYCLES  = STEP_GAP_CYCLES_DEF,
  parameter int PEND_WIDTH       = PEND_WIDTH_DEF,
  parameter int POS_WIDTH        = POS_WIDTH_DEF
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step_in,
  input  logic                  dir_in,
  input  logic                  enable,
  input  logic                  invert_step,
  input  logic                  invert_dir,
  input  logic                  pos_clear,
  input  logic                  fault_clear,
  output logic                  step_out,
  output logic                  dir_out,
  output logic [POS_WIDTH-1:0]  position,
  output logic [PEND_WIDTH-1:0] pending,
  output logic                  overflow,
  output logic                  dir_fault
);
  localparam int SW = $clog2(DIR_SETUP_CYCLES + 1);
  localparam int GW = $clog2(STEP_GAP_CYCLES + 1);
  localparam logic [PEND_WIDTH-1:0] PMAX = '1;
  state_t                r_state, w_state;
  logic [PEND_WIDTH-1:0] r_cur, r_nxt, w_cur, w_nxt;
  logic [SW-1:0]         r_settle, w_settle;
  logic [GW-1:0]         r_gap, w_gap;
  logic [POS_WIDTH-1:0]  r_pos;
  logic                  r_dir, w_dir, r_tgt, w_tgt, r_step_d, r_dir_d, r_ovf, r_flt;
  logic                  w_step_f, w_dir_f, w_step_evt, w_dir_evt, w_pulse, w_ovf, w_flt;

  sync_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_step (
    .clk(clk), .reset(reset), .d(step_in), .inv(invert_step), .q(w_step_f));
  sync_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_dir (
    .clk(clk), .reset(reset), .d(dir_in), .inv(invert_dir), .q(w_dir_f));

  assign w_step_evt = enable && w_step_f && !r_step_d;
  assign w_dir_evt  = enable && (w_dir_f ^ r_dir_d);
  assign w_pulse    = enable && r_cur != '0 && r_gap == '0 && r_settle == '0;
  assign step_out   = w_pulse;
  assign dir_out    = r_dir;
  assign position   = r_pos;
  assign pending    = r_cur;
  assign overflow   = r_ovf;
  assign dir_fault  = r_flt;

  // Gap loads one less than the spacing so pulses land exactly STEP_GAP_CYCLES apart
  always_comb begin
    w_state  = r_state;
    w_cur    = r_cur - PEND_WIDTH'(w_pulse);
    w_nxt    = r_nxt;
    w_dir    = r_dir;
    w_tgt    = w_dir_evt ? w_dir_f : r_tgt;
    w_settle = r_settle - SW'(r_settle != '0);
    w_gap    = w_pulse ? GW'(STEP_GAP_CYCLES - 1) : r_gap - GW'(r_gap != '0);
    w_ovf    = 1'b0;
    w_flt    = 1'b0;
    if (r_state == ST_RUN) begin
      w_ovf = w_step_evt && !w_pulse && r_cur == PMAX;
      w_cur = w_step_evt ? ((w_pulse || w_ovf) ? r_cur : r_cur + 1'b1) : w_cur;
      if (w_dir_evt && r_cur == '0) begin
        w_dir    = w_dir_f;
        w_settle = SW'(DIR_SETUP_CYCLES);
      end else if (w_dir_evt) begin
        w_state = ST_HOLD;
      end
    end else begin
      w_ovf = w_step_evt && r_nxt == PMAX;
      w_nxt = (w_step_evt && !w_ovf) ? r_nxt + 1'b1 : r_nxt;
      w_flt = w_dir_evt;
      if (r_cur == '0) begin
        w_dir    = w_tgt;
        w_settle = SW'(DIR_SETUP_CYCLES);
        w_cur    = w_nxt;
        w_nxt    = '0;
        w_state  = ST_RUN;
      end
    end
    if (!enable) begin
      w_cur   = '0;
      w_nxt   = '0;
      w_state = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_cur    <= '0;
      r_nxt    <= '0;
      r_settle <= '0;
      r_gap    <= '0;
      r_pos    <= '0;
      r_dir    <= 1'b0;
      r_tgt    <= 1'b0;
      r_step_d <= 1'b0;
      r_dir_d  <= 1'b0;
      r_ovf    <= 1'b0;
      r_flt    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cur    <= w_cur;
      r_nxt    <= w_nxt;
      r_settle <= w_settle;
      r_gap    <= w_gap;
      r_pos    <= pos_clear ? '0 : w_pulse ? (r_dir ? r_pos + 1'b1 : r_pos - 1'b1) : r_pos;
      r_dir    <= w_dir;
      r_tgt    <= w_tgt;
      r_step_d <= w_step_f;
      r_dir_d  <= w_dir_f;
      r_ovf    <= w_ovf || (r_ovf && !fault_clear);
      r_flt    <= w_flt || (r_flt && !fault_clear);
    end
  end
endmodule
